// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter: shares one single-port block RAM between clients A and B.
// Round-robin arbitration with an optional ownership lock for read-modify-write.
// The RAM port is driven combinationally from the winning client. Read data
// comes back through a registered path, two cycles after the grant.
//
// Handshake: x_gnt is combinational and means "this cycle's request is taken".
// A client keeps req/we/addr/wdata stable until it sees gnt=1. For a read
// granted in cycle T, x_rvalid pulses for exactly cycle T+2 and x_rdata holds
// the value from then until that client's next read completes.
module block_ram_arbiter #(
   parameter int RAM_WIDTH = 8,
   parameter int RAM_DEPTH = 256,
   parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic                 a_lock,
   input  logic [ADDR_W-1:0]    a_addr,
   input  logic [RAM_WIDTH-1:0] a_wdata,
   output logic                 a_gnt,
   output logic                 a_rvalid,
   output logic [RAM_WIDTH-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic                 b_lock,
   input  logic [ADDR_W-1:0]    b_addr,
   input  logic [RAM_WIDTH-1:0] b_wdata,
   output logic                 b_gnt,
   output logic                 b_rvalid,
   output logic [RAM_WIDTH-1:0] b_rdata,
   output logic                 ram_we,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic [RAM_WIDTH-1:0] ram_din,
   input  logic [RAM_WIDTH-1:0] ram_dout,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   state_t r_state;
   logic   r_last;      // 0 = A won last, 1 = B won last
   logic   r_pend;      // a read was granted last cycle
   logic   r_pend_tag;  // owner of that read: 0 = A, 1 = B
   logic   w_gnt_a;
   logic   w_gnt_b;

   // Grant decision: the lock owner has priority; in FREE the client not equal to last wins ties.
   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (rst_n) begin
         case (r_state)
            LOCK_A: begin
               if (a_req)                 w_gnt_a = 1'b1;
               else if (!a_lock && b_req) w_gnt_b = 1'b1;
            end
            LOCK_B: begin
               if (b_req)                 w_gnt_b = 1'b1;
               else if (!b_lock && a_req) w_gnt_a = 1'b1;
            end
            default: begin
               if (a_req && b_req) begin
                  w_gnt_a = r_last;
                  w_gnt_b = !r_last;
               end else begin
                  w_gnt_a = a_req;
                  w_gnt_b = b_req;
               end
            end
         endcase
      end
   end

   assign a_gnt     = w_gnt_a;
   assign b_gnt     = w_gnt_b;
   assign dbg_state = r_state;

   // RAM port mux: winner's command, all zeros when nobody is granted.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      if (w_gnt_a) begin
         ram_we   = a_we;
         ram_addr = a_addr;
         ram_din  = a_wdata;
      end else if (w_gnt_b) begin
         ram_we   = b_we;
         ram_addr = b_addr;
         ram_din  = b_wdata;
      end
   end

   // Arbitration FSM: lock state and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FREE;
         r_last  <= 1'b1;
      end else begin
         if (w_gnt_a)      r_last <= 1'b0;
         else if (w_gnt_b) r_last <= 1'b1;

         if (w_gnt_a && a_lock)                 r_state <= LOCK_A;
         else if (w_gnt_b && b_lock)            r_state <= LOCK_B;
         else if (r_state == LOCK_A && a_lock)  r_state <= LOCK_A;
         else if (r_state == LOCK_B && b_lock)  r_state <= LOCK_B;
         else                                   r_state <= FREE;
      end
   end

   // Read response pipeline: tag at grant, capture ram_dout one cycle later, pulse rvalid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend     <= 1'b0;
         r_pend_tag <= 1'b0;
         a_rvalid   <= 1'b0;
         b_rvalid   <= 1'b0;
         a_rdata    <= '0;
         b_rdata    <= '0;
      end else begin
         r_pend     <= (w_gnt_a && !a_we) || (w_gnt_b && !b_we);
         r_pend_tag <= w_gnt_b;
         a_rvalid   <= r_pend && !r_pend_tag;
         b_rvalid   <= r_pend && r_pend_tag;
         if (r_pend && !r_pend_tag) a_rdata <= ram_dout;
         if (r_pend && r_pend_tag)  b_rdata <= ram_dout;
      end
   end

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Bench for block_ram_arbiter: a directed vector table for the named scenarios,
// then random traffic. Every cycle is also checked against a transaction-level
// reference model (memory array plus a queue of outstanding reads with due cycles).
module tb_block_ram_arbiter;

  localparam int W = 8;
  localparam int AW = 8;
  localparam int N_VEC = 34;
  localparam int N_RAND = 3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [W-1:0]  a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [W-1:0]  b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [W-1:0]  a_rdata, b_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_din;
  logic [W-1:0]  ram_dout;
  logic [1:0]    dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  block_ram_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .dbg_state(dbg_state)
  );

  // block RAM: single port, registered read-first output, mem[i] = i at start
  logic [W-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = W'(i);
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic rst_n;
    logic a_req, a_we, a_lock; logic [7:0] a_addr, a_wdata;
    logic b_req, b_we, b_lock; logic [7:0] b_addr, b_wdata;
    logic e_ag, e_bg, e_arv; logic [7:0] e_ard;
    logic e_brv; logic [7:0] e_brd;
  } vec_t;

  typedef struct {
    bit         client;  // 0 = A, 1 = B
    logic [W-1:0] data;
    int         due;
  } rd_t;

  // reference model state
  logic [W-1:0] m_mem [256];
  int           m_state;   // 0 free, 1 locked by A, 2 locked by B
  int           m_last;    // 0 = A, 1 = B
  logic [W-1:0] m_rdata [2];
  rd_t          pend_q[$];
  logic [W-1:0] exp_q[$];  // scoreboard: read data expected, in completion order
  int           cyc = 0;

  int total = 0;
  int bad = 0;

  vec_t vecs [N_VEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last = 1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    pend_q.delete();
    exp_q.delete();
  endtask

  function automatic vec_t mk(input logic r, input logic ar, aw, al, input logic [7:0] aa, ad,
                              input logic br, bw, bl, input logic [7:0] ba, bd,
                              input logic eag, ebg, earv, input logic [7:0] eard,
                              input logic ebrv, input logic [7:0] ebrd);
    vec_t v;
    v.rst_n = r;
    v.a_req = ar; v.a_we = aw; v.a_lock = al; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_lock = bl; v.b_addr = ba; v.b_wdata = bd;
    v.e_ag = eag; v.e_bg = ebg; v.e_arv = earv; v.e_ard = eard;
    v.e_brv = ebrv; v.e_brd = ebrd;
    return v;
  endfunction

  // driver + per-cycle check against model (and optionally against the table row)
  task automatic step(input vec_t v, input bit chk_tbl);
    int win;
    logic exp_rv [2];
    logic exp_we;
    logic [AW-1:0] exp_addr;
    logic [W-1:0] exp_din;
    @(posedge clk);
    #1;
    rst_n = v.rst_n;
    a_req = v.a_req; a_we = v.a_we; a_lock = v.a_lock; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_lock = v.b_lock; b_addr = v.b_addr; b_wdata = v.b_wdata;
    @(negedge clk);

    // reads completing this cycle
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rd_t r;
      r = pend_q.pop_front();
      exp_rv[r.client] = 1'b1;
      m_rdata[r.client] = exp_q.pop_front();
    end

    // who should win this cycle
    win = -1;
    if (rst_n) begin
      if (m_state == 1)      win = a_req ? 0 : ((!a_lock && b_req) ? 1 : -1);
      else if (m_state == 2) win = b_req ? 1 : ((!b_lock && a_req) ? 0 : -1);
      else if (a_req && b_req) win = (m_last == 0) ? 1 : 0;
      else if (a_req)        win = 0;
      else if (b_req)        win = 1;
    end
    exp_we = 1'b0; exp_addr = '0; exp_din = '0;
    if (win == 0) begin exp_we = a_we; exp_addr = a_addr; exp_din = a_wdata; end
    if (win == 1) begin exp_we = b_we; exp_addr = b_addr; exp_din = b_wdata; end

    chk("a_gnt", 32'(a_gnt), 32'(win == 0));
    chk("b_gnt", 32'(b_gnt), 32'(win == 1));
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
    chk("ram_din", 32'(ram_din), 32'(exp_din));
    chk("a_rvalid", 32'(a_rvalid), 32'(exp_rv[0]));
    chk("b_rvalid", 32'(b_rvalid), 32'(exp_rv[1]));
    chk("a_rdata", 32'(a_rdata), 32'(m_rdata[0]));
    chk("b_rdata", 32'(b_rdata), 32'(m_rdata[1]));
    chk("state", 32'(dbg_state), 32'(m_state));

    if (chk_tbl) begin
      chk("tbl_a_gnt", 32'(a_gnt), 32'(v.e_ag));
      chk("tbl_b_gnt", 32'(b_gnt), 32'(v.e_bg));
      chk("tbl_a_rvalid", 32'(a_rvalid), 32'(v.e_arv));
      chk("tbl_a_rdata", 32'(a_rdata), 32'(v.e_ard));
      chk("tbl_b_rvalid", 32'(b_rvalid), 32'(v.e_brv));
      chk("tbl_b_rdata", 32'(b_rdata), 32'(v.e_brd));
    end

    // advance model across the coming clock edge
    if (!rst_n) begin
      model_reset();
    end else begin
      int nxt;
      if (win >= 0) begin
        m_last = win;
        if (exp_we) m_mem[exp_addr] = exp_din;
        else begin
          rd_t r;
          r.client = (win == 1);
          r.data = m_mem[exp_addr];
          r.due = cyc + 2;
          pend_q.push_back(r);
          exp_q.push_back(m_mem[exp_addr]);
        end
      end
      if (win == 0 && a_lock)             nxt = 1;
      else if (win == 1 && b_lock)        nxt = 2;
      else if (m_state == 1 && a_lock)    nxt = 1;
      else if (m_state == 2 && b_lock)    nxt = 2;
      else                                nxt = 0;
      m_state = nxt;
    end
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = W'(i);
    model_reset();

    //             rst ar aw al aa     ad     br bw bl ba     bd     ag bg arv ard    brv brd
    vecs[0]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    vecs[1]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    // A writes 0x10=A5, then reads it back
    vecs[2]  = mk(1, 1, 1, 0, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    vecs[3]  = mk(1, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    vecs[4]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    vecs[5]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'hA5, 0, 8'h00);
    vecs[6]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hA5, 0, 8'h00);
    // reset, then both read every cycle: A,B,A,B
    vecs[7]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hA5, 0, 8'h00);
    vecs[8]  = mk(1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    vecs[9]  = mk(1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);
    vecs[10] = mk(1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 1, 0, 1, 8'h01, 0, 8'h00);
    vecs[11] = mk(1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1, 0, 8'h01, 1, 8'h02);
    vecs[12] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h01, 0, 8'h02);
    vecs[13] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 1, 8'h02);
    vecs[14] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, 8'h02);
    // locked read-modify-write by A blocks B for two cycles
    vecs[15] = mk(1, 1, 0, 1, 8'h20, 8'h00, 1, 0, 0, 8'h05, 8'h00, 1, 0, 0, 8'h01, 0, 8'h02);
    vecs[16] = mk(1, 1, 1, 0, 8'h20, 8'h77, 1, 0, 0, 8'h05, 8'h00, 1, 0, 0, 8'h01, 0, 8'h02);
    vecs[17] = mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h05, 8'h00, 0, 1, 1, 8'h20, 0, 8'h02);
    vecs[18] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h20, 0, 8'h02);
    vecs[19] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h20, 1, 8'h05);
    // B reads 0x30, A overwrites it next cycle, B reads again
    vecs[20] = mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h30, 8'h00, 0, 1, 0, 8'h20, 0, 8'h05);
    vecs[21] = mk(1, 1, 1, 0, 8'h30, 8'hC3, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 0, 8'h05);
    vecs[22] = mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h30, 8'h00, 0, 1, 0, 8'h20, 1, 8'h30);
    vecs[23] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h20, 0, 8'h30);
    vecs[24] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h20, 1, 8'hC3);
    // read in flight when reset hits: dropped
    vecs[25] = mk(1, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 0, 8'hC3);
    vecs[26] = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h20, 0, 8'hC3);
    vecs[27] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    vecs[28] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    // lock held while A idles keeps B out; released when a_lock drops
    vecs[29] = mk(1, 1, 0, 1, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    vecs[30] = mk(1, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    vecs[31] = mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1, 1, 8'h01, 0, 8'h00);
    vecs[32] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, 8'h00);
    vecs[33] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 1, 8'h02);

    for (int i = 0; i < N_VEC; i++) step(vecs[i], 1'b1);

    // random traffic, small address range to force read/write collisions
    for (int i = 0; i < N_RAND; i++) begin
      vec_t v;
      v = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
      v.rst_n   = ($urandom_range(0, 63) != 0);
      v.a_req   = ($urandom_range(0, 3) != 0);
      v.a_we    = ($urandom_range(0, 2) == 0);
      v.a_lock  = ($urandom_range(0, 3) == 0);
      v.a_addr  = 8'($urandom_range(0, 15));
      v.a_wdata = 8'($urandom_range(0, 255));
      v.b_req   = ($urandom_range(0, 3) != 0);
      v.b_we    = ($urandom_range(0, 2) == 0);
      v.b_lock  = ($urandom_range(0, 3) == 0);
      v.b_addr  = 8'($urandom_range(0, 15));
      v.b_wdata = 8'($urandom_range(0, 255));
      step(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
